// File: rtl/timer_arbiter.sv
// Shared one-shot delay timer, time-multiplexed between N_REQ requesters.
// A round-robin arbiter picks one requester, loads its tick count, and the
// timer counts that many prescaled base ticks before pulsing done.
module timer_arbiter #(
    parameter int unsigned CLK_FREQ = 12_000_000,
    parameter int unsigned TICK_HZ  = 1000,
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] req_ticks,
    input  logic [N_REQ-1:0]       abort,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy,
    output logic [N_REQ-1:0]       done,
    output logic                   tick
);

    localparam int unsigned DIV   = CLK_FREQ / TICK_HZ;
    localparam int unsigned PS_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Prescaler value at the wrap, and the value one cycle before it; tick is
    // registered off the latter so it is high exactly while prescaler == DIV-1.
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(DIV - 1);
    localparam logic [PS_W-1:0]  PS_PRE   = PS_W'(DIV - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    // Reject unusable parameter sets at elaboration
    generate
        if (DIV < 2) begin : g_div_check
            $error("timer_arbiter: CLK_FREQ/TICK_HZ must be at least 2");
        end
        if ((N_REQ < 2) || (N_REQ > 8)) begin : g_nreq_check
            $error("timer_arbiter: N_REQ must be in 2..8");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [PS_W-1:0]    prescaler;
    logic [CNT_W-1:0]   remaining;
    logic [IDX_W-1:0]   last_grant;

    logic [CNT_W-1:0]   ticks_arr [N_REQ];
    logic [IDX_W-1:0]   sel;
    logic               found;
    logic               any_req;
    int unsigned        rr_idx;
    logic [CNT_W-1:0]   sel_ticks;
    logic               wrap;
    logic               last_tick;
    logic               abort_hit;

    logic [N_REQ-1:0]   grant_nx;
    logic               busy_nx;
    logic [N_REQ-1:0]   done_nx;
    logic               tick_nx;

    // Unpack the per-requester tick counts
    for (genvar i = 0; i < int'(N_REQ); i++) begin : g_ticks
        assign ticks_arr[i] = req_ticks[i*CNT_W +: CNT_W];
    end

    // Round-robin pick: first set req bit searching upward from last_grant+1
    always_comb begin
        sel     = last_grant;
        found   = 1'b0;
        rr_idx  = 0;
        any_req = |req;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            rr_idx = (32'(last_grant) + off) % N_REQ;
            if (!found && req[IDX_W'(rr_idx)]) begin
                found = 1'b1;
                sel   = IDX_W'(rr_idx);
            end
        end
    end

    assign sel_ticks = ticks_arr[sel];
    assign wrap      = (prescaler == PS_LAST);
    assign last_tick = (remaining == CNT_W'(1));
    // Only the granted requester's abort bit can cancel a running delay
    assign abort_hit = (state == ST_RUN) && abort[last_grant];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nx = (sel_ticks != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (abort_hit) begin
                    state_nx = ST_IDLE;
                end else if (wrap && last_tick) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        grant_nx = '0;
        busy_nx  = 1'b0;
        done_nx  = '0;
        tick_nx  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    if (sel_ticks != '0) begin
                        grant_nx[sel] = 1'b1;
                        busy_nx       = 1'b1;
                    end else begin
                        done_nx[sel] = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (!abort_hit) begin
                    if (wrap && last_tick) begin
                        done_nx[last_grant] = 1'b1;
                    end else begin
                        grant_nx[last_grant] = 1'b1;
                        busy_nx              = 1'b1;
                        tick_nx              = (prescaler == PS_PRE);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant <= '0;
            busy  <= 1'b0;
            done  <= '0;
            tick  <= 1'b0;
        end else begin
            grant <= grant_nx;
            busy  <= busy_nx;
            done  <= done_nx;
            tick  <= tick_nx;
        end
    end

    // Prescaler, remaining-tick counter and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler  <= '0;
            remaining  <= '0;
            last_grant <= IDX_LAST;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        remaining  <= sel_ticks;
                        last_grant <= sel;
                        prescaler  <= '0;
                    end
                end
                ST_RUN: begin
                    if (abort_hit) begin
                        prescaler <= '0;
                        remaining <= '0;
                    end else if (wrap) begin
                        prescaler <= '0;
                        remaining <= remaining - CNT_W'(1);
                    end else begin
                        prescaler <= prescaler + PS_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Self-checking bench for timer_arbiter: directed scenarios plus random
// traffic, all compared each cycle against a timeline model of the arbiter.
module tb_timer_arbiter;

    localparam int CLK_FREQ = 100;
    localparam int TICK_HZ  = 10;
    localparam int N_REQ    = 4;
    localparam int CNT_W    = 8;
    localparam int DIV      = CLK_FREQ / TICK_HZ;

    logic                   clk;
    logic                   rst_n;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*CNT_W-1:0] req_ticks;
    logic [N_REQ-1:0]       abort;
    logic [N_REQ-1:0]       grant;
    logic                   busy;
    logic [N_REQ-1:0]       done;
    logic                   tick;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: edge counter plus a grant timeline
    int ecnt     = 0;
    int m_owner  = -1;
    int m_last   = N_REQ - 1;
    int m_sample = 1;
    int m_gstart = 0;
    int m_k      = 0;
    logic [N_REQ-1:0] exp_grant;
    logic             exp_busy;
    logic [N_REQ-1:0] exp_done;
    logic             exp_tick;

    timer_arbiter #(
        .CLK_FREQ (CLK_FREQ),
        .TICK_HZ  (TICK_HZ),
        .N_REQ    (N_REQ),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_ticks (req_ticks),
        .abort     (abort),
        .grant     (grant),
        .busy      (busy),
        .done      (done),
        .tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic string act_s();
        return $sformatf("g=%b b=%b d=%b t=%b", grant, busy, done, tick);
    endfunction

    function automatic string exp_s();
        return $sformatf("g=%b b=%b d=%b t=%b", exp_grant, exp_busy, exp_done, exp_tick);
    endfunction

    function automatic int oh_idx(input logic [N_REQ-1:0] v);
        for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic set_ticks(input int i, input int v);
        req_ticks[i*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    // Expected outputs after the next edge, from the grant timeline:
    // a grant of k ticks lasts k*DIV cycles, tick marks each DIV-th cycle,
    // done follows the last one, and the arbiter re-samples two edges later.
    task automatic model_edge();
        int e, n, sel, k;
        logic [N_REQ-1:0] eg, ed;
        logic eb, et;
        eg = '0; ed = '0; eb = 1'b0; et = 1'b0; sel = -1;
        e = ecnt + 1;
        if (m_owner >= 0) begin
            n = e - m_gstart;
            if (abort[m_owner]) begin
                m_owner  = -1;
                m_sample = e + 1;
            end else if (n == m_k * DIV) begin
                ed[m_owner] = 1'b1;
                m_owner     = -1;
                m_sample    = e + 2;
            end else begin
                eg[m_owner] = 1'b1;
                eb          = 1'b1;
                et          = ((n % DIV) == DIV - 1);
            end
        end else if (e >= m_sample && req != '0) begin
            for (int off = 1; off <= N_REQ; off++) begin
                if (sel < 0 && req[(m_last + off) % N_REQ]) sel = (m_last + off) % N_REQ;
            end
            m_last = sel;
            k = int'(req_ticks[sel*CNT_W +: CNT_W]);
            if (k == 0) begin
                ed[sel]  = 1'b1;
                m_sample = e + 2;
            end else begin
                m_owner  = sel;
                m_gstart = e;
                m_k      = k;
                eg[sel]  = 1'b1;
                eb       = 1'b1;
            end
        end
        exp_grant = eg; exp_busy = eb; exp_done = ed; exp_tick = et;
        ecnt = e;
    endtask

    // Advance one clock; called and returns at a falling edge
    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_last   = N_REQ - 1;
        m_sample = ecnt + 1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; abort = '0; req_ticks = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({grant, busy, done, tick} !== '0) begin
            n_fail++; $display("FAIL reset_values got %s required all zero", act_s());
        end
        for (int c = 0; c < 3; c++) begin
            cycle();
            n_checks++;
            if ({grant, busy, done, tick} !== {exp_grant, exp_busy, exp_done, exp_tick}) begin
                n_fail++; $display("FAIL reset_idle e=%0d got %s exp %s", ecnt, act_s(), exp_s());
            end
        end
    endtask

    task automatic test_single();
        int gc, tc, g_e, d_e, t0;
        gc = 0; tc = 0; g_e = -1; d_e = -1;
        set_ticks(0, 3); req = 4'b0001; t0 = ecnt + 1;
        for (int c = 0; c < 40; c++) begin
            cycle();
            n_checks++;
            if ({grant, busy, done, tick} !== {exp_grant, exp_busy, exp_done, exp_tick}) begin
                n_fail++; $display("FAIL single e=%0d got %s exp %s", ecnt, act_s(), exp_s());
            end
            if (grant[0]) begin gc++; if (g_e < 0) g_e = ecnt; end
            if (tick) tc++;
            if (done[0]) begin d_e = ecnt; req[0] = 1'b0; end
        end
        n_checks++;
        if (g_e !== t0) begin n_fail++; $display("FAIL single_latency got %0d required %0d", g_e, t0); end
        n_checks++;
        if (gc !== 30) begin n_fail++; $display("FAIL single_grant_len got %0d required 30", gc); end
        n_checks++;
        if (tc !== 3) begin n_fail++; $display("FAIL single_ticks got %0d required 3", tc); end
        n_checks++;
        if (d_e !== t0 + 30) begin n_fail++; $display("FAIL single_done_time got %0d required %0d", d_e, t0 + 30); end
    endtask

    task automatic test_fairness();
        int starts[$];
        int owners[$];
        logic [N_REQ-1:0] prev;
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_ticks(i, 1);
        req = 4'b1111; prev = '0;
        for (int c = 0; c < 80; c++) begin
            cycle();
            n_checks++;
            if ({grant, busy, done, tick} !== {exp_grant, exp_busy, exp_done, exp_tick}) begin
                n_fail++; $display("FAIL fairness e=%0d got %s exp %s", ecnt, act_s(), exp_s());
            end
            if (grant != '0 && prev == '0) begin
                starts.push_back(ecnt);
                owners.push_back(oh_idx(grant));
            end
            prev = grant;
            if (starts.size() == 5) req = '0;
        end
        n_checks++;
        if (starts.size() != 5) begin
            n_fail++; $display("FAIL fairness_count got %0d grants required 5", starts.size());
        end
        for (int i = 0; i < owners.size(); i++) begin
            n_checks++;
            if (owners[i] != i % N_REQ) begin
                n_fail++; $display("FAIL fairness_order slot %0d got %0d required %0d", i, owners[i], i % N_REQ);
            end
            if (i > 0) begin
                n_checks++;
                if (starts[i] - starts[i-1] != DIV + 2) begin
                    n_fail++; $display("FAIL fairness_spacing slot %0d got %0d required %0d", i, starts[i] - starts[i-1], DIV + 2);
                end
            end
        end
    endtask

    task automatic test_zero();
        int d_e, t0;
        logic gseen;
        d_e = -1; gseen = 1'b0;
        for (int c = 0; c < 4; c++) cycle();
        set_ticks(2, 0); req = 4'b0100; t0 = ecnt + 1;
        for (int c = 0; c < 6; c++) begin
            cycle();
            n_checks++;
            if ({grant, busy, done, tick} !== {exp_grant, exp_busy, exp_done, exp_tick}) begin
                n_fail++; $display("FAIL zero e=%0d got %s exp %s", ecnt, act_s(), exp_s());
            end
            if (grant != '0) gseen = 1'b1;
            if (done[2] && d_e < 0) begin d_e = ecnt; req[2] = 1'b0; end
        end
        n_checks++;
        if (d_e !== t0) begin n_fail++; $display("FAIL zero_done_time got %0d required %0d", d_e, t0); end
        n_checks++;
        if (gseen !== 1'b0) begin n_fail++; $display("FAIL zero_no_grant got %b required 0", gseen); end
    endtask

    task automatic test_abort();
        int gc, gc0;
        logic ab, dseen, d0seen;
        gc = 0; gc0 = 0; ab = 1'b0; dseen = 1'b0; d0seen = 1'b0;
        set_ticks(1, 5); req = 4'b0010;
        for (int c = 0; c < 70; c++) begin
            abort = '0;
            if (gc == 23 && !ab) begin abort[1] = 1'b1; req[1] = 1'b0; ab = 1'b1; end
            cycle();
            n_checks++;
            if ({grant, busy, done, tick} !== {exp_grant, exp_busy, exp_done, exp_tick}) begin
                n_fail++; $display("FAIL abort e=%0d got %s exp %s", ecnt, act_s(), exp_s());
            end
            if (grant[1]) gc++;
            if (done[1]) dseen = 1'b1;
        end
        n_checks++;
        if (gc !== 23) begin n_fail++; $display("FAIL abort_grant_len got %0d required 23", gc); end
        n_checks++;
        if (dseen !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got %b required 0", dseen); end
        set_ticks(0, 2); req = 4'b0001;
        for (int c = 0; c < 30; c++) begin
            cycle();
            n_checks++;
            if ({grant, busy, done, tick} !== {exp_grant, exp_busy, exp_done, exp_tick}) begin
                n_fail++; $display("FAIL abort_next e=%0d got %s exp %s", ecnt, act_s(), exp_s());
            end
            if (grant[0]) gc0++;
            if (done[0]) begin d0seen = 1'b1; req[0] = 1'b0; end
        end
        n_checks++;
        if (gc0 !== 20 || d0seen !== 1'b1) begin
            n_fail++; $display("FAIL abort_next_served got len=%0d done=%b required len=20 done=1", gc0, d0seen);
        end
    endtask

    task automatic test_ignored();
        int gc;
        logic dseen;
        gc = 0; dseen = 1'b0;
        set_ticks(1, 5); req = 4'b0010;
        for (int c = 0; c < 70; c++) begin
            abort = '0;
            if (gc == 7) set_ticks(1, 200);
            if (gc == 15) abort[3] = 1'b1;
            cycle();
            n_checks++;
            if ({grant, busy, done, tick} !== {exp_grant, exp_busy, exp_done, exp_tick}) begin
                n_fail++; $display("FAIL ignored e=%0d got %s exp %s", ecnt, act_s(), exp_s());
            end
            if (grant[1]) gc++;
            if (done[1]) begin dseen = 1'b1; req[1] = 1'b0; end
        end
        abort = '0;
        n_checks++;
        if (gc !== 50) begin n_fail++; $display("FAIL ignored_grant_len got %0d required 50", gc); end
        n_checks++;
        if (dseen !== 1'b1) begin n_fail++; $display("FAIL ignored_done got %b required 1", dseen); end
    endtask

    task automatic test_random();
        int ndone;
        ndone = 0;
        for (int i = 0; i < N_REQ; i++) set_ticks(i, int'($urandom_range(0, 3)));
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
                if ($urandom_range(0, 15) == 0) set_ticks(i, int'($urandom_range(0, 3)));
            end
            abort = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            cycle();
            n_checks++;
            if ({grant, busy, done, tick} !== {exp_grant, exp_busy, exp_done, exp_tick}) begin
                n_fail++; $display("FAIL random e=%0d got %s exp %s", ecnt, act_s(), exp_s());
            end
            if (done != '0) ndone++;
        end
        abort = '0;
        n_checks++;
        if (ndone == 0) begin n_fail++; $display("FAIL random_activity got %0d done pulses required >0", ndone); end
    endtask

    task automatic test_reset_mid_run();
        int first, second;
        first = -1; second = -1;
        do_reset();
        set_ticks(2, 2); req = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            cycle();
            n_checks++;
            if ({grant, busy, done, tick} !== {exp_grant, exp_busy, exp_done, exp_tick}) begin
                n_fail++; $display("FAIL midreset_pre e=%0d got %s exp %s", ecnt, act_s(), exp_s());
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({grant, busy, done, tick} !== '0) begin
            n_fail++; $display("FAIL midreset_async got %s required all zero", act_s());
        end
        @(negedge clk);
        @(negedge clk);
        req = 4'b1001; set_ticks(0, 1); set_ticks(3, 1);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 40; c++) begin
            cycle();
            n_checks++;
            if ({grant, busy, done, tick} !== {exp_grant, exp_busy, exp_done, exp_tick}) begin
                n_fail++; $display("FAIL midreset_post e=%0d got %s exp %s", ecnt, act_s(), exp_s());
            end
            if (grant != '0 && first < 0) first = oh_idx(grant);
            else if (grant != '0 && oh_idx(grant) != first && second < 0) second = oh_idx(grant);
            req = req & ~done;
        end
        n_checks++;
        if (first !== 0) begin n_fail++; $display("FAIL midreset_first got %0d required 0", first); end
        n_checks++;
        if (second !== 3) begin n_fail++; $display("FAIL midreset_second got %0d required 3", second); end
    endtask

    initial begin
        rst_n = 1'b0; req = '0; abort = '0; req_ticks = '0;
        test_reset();
        test_single();
        test_fairness();
        test_zero();
        test_abort();
        test_ignored();
        test_random();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
